// File: rtl/shifter.sv
// Branch-offset shifter: registered logical left shift by a fixed SHIFT_AMT,
// built as a log2(WIDTH)-stage barrel network followed by one output register.

module shifter_stage #(
   parameter int WIDTH = 32,
   parameter int DIST  = 1,
   parameter bit EN    = 1'b0
) (
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out
);
   // EN is a constant, so this folds to either wires or a fixed rewiring.
   assign d_out = EN ? (d_in << DIST) : d_in;
endmodule

module shifter #(
   parameter int WIDTH     = 32,
   parameter int SHIFT_AMT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic             in_valid,
   output logic [WIDTH-1:0] Z,
   output logic             out_valid
);
   localparam int STAGES = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [STAGES:0][WIDTH-1:0] stg;
   logic [WIDTH-1:0]           z_d, z_q;
   logic                       valid_d, valid_q;

   assign stg[0] = A;

   // Stage k contributes 2^k of the shift when bit k of SHIFT_AMT is set.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam bit EN_K   = ((SHIFT_AMT >> k) & 1) != 0;
      localparam int DIST_K = 1 << k;
      shifter_stage #(
         .WIDTH (WIDTH),
         .DIST  (DIST_K),
         .EN    (EN_K)
      ) u_stage (
         .d_in  (stg[k]),
         .d_out (stg[k+1])
      );
   end

   always_comb begin
      z_d     = stg[STAGES];
      valid_d = in_valid;
   end

   // Z loads every cycle; in_valid only qualifies it through out_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         z_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         z_q     <= z_d;
         valid_q <= valid_d;
      end
   end

   assign Z         = z_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_shifter.sv
// Scoreboard bench: driver queues expected results per edge, monitor pops and
// compares one cycle later for a SHIFT_AMT=2 and a SHIFT_AMT=0 instance.

module tb_shifter;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a;
   logic        in_valid;
   logic [31:0] z2, z0;
   logic        ov2, ov0;

   always #5 clk = ~clk;

   shifter #(.WIDTH(32), .SHIFT_AMT(2)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .A         (a),
      .in_valid  (in_valid),
      .Z         (z2),
      .out_valid (ov2)
   );

   shifter #(.WIDTH(32), .SHIFT_AMT(0)) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .A         (a),
      .in_valid  (in_valid),
      .Z         (z0),
      .out_valid (ov0)
   );

   typedef struct {
      logic        v;
      logic [31:0] z2;
      logic [31:0] z0;
      int          id;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_n  = 0;

   function automatic void chk(input string nm, input int id,
                               input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d got %h want %h", nm, id, act, exp);
      end
   endfunction

   // Drive one edge's inputs; ez2 is the expected SHIFT_AMT=2 result when rst=0.
   task automatic drive(input logic r, input logic [31:0] av, input logic v,
                        input logic [31:0] ez2);
      exp_t e;
      @(negedge clk);
      rst      = r;
      a        = av;
      in_valid = v;
      e.v  = r ? 1'b0  : v;
      e.z2 = r ? 32'h0 : ez2;
      e.z0 = r ? 32'h0 : av;
      e.id = vec_n;
      vec_n++;
      q.push_back(e);
   endtask

   // Monitor: every edge the DUT presents a new Z/out_valid; check it 1ns later.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_valid_s2", e.id, {31'b0, ov2}, {31'b0, e.v});
            chk("z_s2",         e.id, z2,           e.z2);
            chk("out_valid_s0", e.id, {31'b0, ov0}, {31'b0, e.v});
            chk("z_s0",         e.id, z0,           e.z0);
         end
      end
   end

   initial begin
      logic [31:0] av;
      logic        v;
      rst      = 1'b1;
      a        = 32'h0;
      in_valid = 1'b0;

      // reset holds Z=0/out_valid=0 even with a valid operand present
      drive(1'b1, 32'hFFFFFFFF, 1'b1, 32'h00000000);
      drive(1'b1, 32'hFFFFFFFF, 1'b1, 32'h00000000);
      drive(1'b0, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFC);
      drive(1'b0, 32'h00000001, 1'b1, 32'h00000004);
      drive(1'b0, 32'h40000000, 1'b1, 32'h00000000);
      drive(1'b0, 32'h12345678, 1'b1, 32'h48D159E0);
      drive(1'b0, 32'h80000003, 1'b1, 32'h0000000C);
      // reset mid-stream drops the valid operand of that cycle
      drive(1'b1, 32'hA5A5A5A5, 1'b1, 32'h00000000);
      drive(1'b0, 32'hA5A5A5A5, 1'b1, 32'h96969694);
      // Z still loads with in_valid low
      drive(1'b0, 32'h00000003, 1'b0, 32'h0000000C);
      drive(1'b0, 32'hC0000001, 1'b0, 32'h00000004);
      drive(1'b0, 32'h3FFFFFFF, 1'b1, 32'hFFFFFFFC);

      for (int i = 0; i < 1000; i++) begin
         av = $urandom;
         v  = 1'($urandom_range(0, 1));
         drive(1'b0, av, v, av << 2);
      end

      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
